// File: rtl/cpu_pkg.sv
// Shared register-file widths, write-enable constant and arbiter FSM states.
package cpu_pkg;

  localparam int unsigned RF_AW = 5;
  localparam int unsigned RF_DW = 32;
  localparam logic [3:0]  RF_WE_ALL = 4'hf;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FORCE
  } arb_state_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-result scoreboard for long-latency destinations with a
// three-index hazard lookup; register 0 never reads as pending.
module rf_scoreboard
  import cpu_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_set_en,
  input  logic [RF_AW-1:0] i_set_addr,
  input  logic             i_clr_en,
  input  logic [RF_AW-1:0] i_clr_addr,
  input  logic [RF_AW-1:0] i_raddr1,
  input  logic [RF_AW-1:0] i_raddr2,
  input  logic [RF_AW-1:0] i_waddr,
  output logic             o_stall
);

  logic [31:0] r_pending;
  logic [31:0] w_pending_nxt;

  // Set is applied after clear so a same-cycle issue wins over a retiring result.
  always_comb begin
    w_pending_nxt = r_pending;
    if (i_clr_en) w_pending_nxt[i_clr_addr] = 1'b0;
    if (i_set_en) w_pending_nxt[i_set_addr] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_pending <= '0;
    else       r_pending <= w_pending_nxt;
  end

  assign o_stall = r_pending[i_raddr1] | r_pending[i_raddr2] | r_pending[i_waddr];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the regfile write port between WB and the long-latency unit,
// forcing a one-cycle pipeline hold when the unit has waited too long.
module rf_wb_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_valid,
  input  logic [RF_AW-1:0] wb_waddr,
  input  logic [RF_DW-1:0] wb_wdata,
  input  logic             lu_valid,
  input  logic [RF_AW-1:0] lu_waddr,
  input  logic [RF_DW-1:0] lu_wdata,
  output logic             lu_ready,
  input  logic             iss_valid,
  input  logic [RF_AW-1:0] iss_rd,
  input  logic [RF_AW-1:0] id_raddr1,
  input  logic [RF_AW-1:0] id_raddr2,
  input  logic [RF_AW-1:0] id_waddr,
  output logic             id_stall,
  output logic             pipe_hold,
  output logic [3:0]       rf_we,
  output logic [RF_AW-1:0] rf_waddr,
  output logic [RF_DW-1:0] rf_wdata
);

  arb_state_t r_state;
  logic [3:0] r_cnt;
  logic       w_gnt_wb;
  logic       w_gnt_lu;
  logic       w_hold;

  always_comb begin
    w_gnt_wb = 1'b0;
    w_gnt_lu = 1'b0;
    w_hold   = 1'b0;
    case (r_state)
      IDLE: begin
        if (lu_valid && !wb_valid) w_gnt_lu = 1'b1;
        else                       w_gnt_wb = wb_valid;
      end
      WAIT: begin
        if (!wb_valid) w_gnt_lu = 1'b1;
        else           w_gnt_wb = 1'b1;
      end
      FORCE: begin
        w_hold   = 1'b1;
        w_gnt_lu = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (lu_valid && wb_valid) begin
            r_cnt   <= 4'd1;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (!wb_valid) begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end else if (r_cnt == 4'(STARVE_LIMIT)) begin
            r_state <= FORCE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        FORCE: begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
        default: begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  rf_scoreboard u_scoreboard (
    .i_clk      (clk),
    .i_rst      (reset),
    .i_set_en   (iss_valid && (iss_rd != '0)),
    .i_set_addr (iss_rd),
    .i_clr_en   (w_gnt_lu),
    .i_clr_addr (lu_waddr),
    .i_raddr1   (id_raddr1),
    .i_raddr2   (id_raddr2),
    .i_waddr    (id_waddr),
    .o_stall    (id_stall)
  );

  assign lu_ready  = w_gnt_lu;
  assign pipe_hold = w_hold;
  assign rf_we     = (w_gnt_lu || w_gnt_wb) ? RF_WE_ALL : '0;
  assign rf_waddr  = w_gnt_lu ? lu_waddr : (w_gnt_wb ? wb_waddr : '0);
  assign rf_wdata  = w_gnt_lu ? lu_wdata : (w_gnt_wb ? wb_wdata : '0);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic checked
// against a waiting-cycle-count model of the arbiter and a pending-bit array.
module tb_rf_wb_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid, lu_valid, iss_valid;
  logic [4:0]  wb_waddr, lu_waddr, iss_rd, id_raddr1, id_raddr2, id_waddr;
  logic [31:0] wb_wdata, lu_wdata;
  logic        lu_ready, id_stall, pipe_hold;
  logic [3:0]  rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int n_pass = 0;
  int n_total = 0;

  // Model: cycles the lu result has been blocked, and per-register pending bits.
  int m_wait;
  bit m_pend[32];
  bit e_lu, e_wb, e_hold, e_stall;
  logic [3:0]  e_we;
  logic [4:0]  e_addr;
  logic [31:0] e_data;

  rf_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .lu_valid(lu_valid), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
    .lu_ready(lu_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .id_raddr1(id_raddr1), .id_raddr2(id_raddr2), .id_waddr(id_waddr),
    .id_stall(id_stall), .pipe_hold(pipe_hold),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  function automatic bit pend_of(input logic [4:0] a);
    return (a == 5'd0) ? 1'b0 : m_pend[a];
  endfunction

  task automatic model_reset();
    m_wait = 0;
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
  endtask

  task automatic model_eval();
    e_lu = 1'b0; e_wb = 1'b0; e_hold = 1'b0;
    if (m_wait == 0) begin
      if (lu_valid && !wb_valid) e_lu = 1'b1;
      else                       e_wb = wb_valid;
    end else if (m_wait == LIMIT + 1) begin
      e_hold = 1'b1; e_lu = 1'b1;
    end else if (!wb_valid) e_lu = 1'b1;
    else                    e_wb = 1'b1;
    e_we   = (e_lu || e_wb) ? 4'hf : 4'h0;
    e_addr = e_lu ? lu_waddr : (e_wb ? wb_waddr : 5'd0);
    e_data = e_lu ? lu_wdata : (e_wb ? wb_wdata : 32'd0);
    e_stall = pend_of(id_raddr1) | pend_of(id_raddr2) | pend_of(id_waddr);
  endtask

  task automatic model_commit();
    if (m_wait == 0)  m_wait = (lu_valid && wb_valid) ? 1 : 0;
    else if (e_lu)    m_wait = 0;
    else              m_wait = m_wait + 1;
    if (e_lu) m_pend[lu_waddr] = 1'b0;
    if (iss_valid && iss_rd != 5'd0) m_pend[iss_rd] = 1'b1;
  endtask

  // Evaluate model with current inputs, then move to the sampling point.
  task automatic settle();
    model_eval();
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle_inputs();
    wb_valid = 0; wb_waddr = 0; wb_wdata = 0;
    lu_valid = 0; lu_waddr = 0; lu_wdata = 0;
    iss_valid = 0; iss_rd = 0;
    id_raddr1 = 0; id_raddr2 = 0; id_waddr = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    settle();
    n_total++; if (rf_we !== 4'h0) $display("FAIL reset_we got %h exp 0", rf_we); else n_pass++;
    n_total++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0)
      $display("FAIL reset_addr_data got %0d/%h exp 0/0", rf_waddr, rf_wdata); else n_pass++;
    n_total++; if ({lu_ready, pipe_hold, id_stall} !== 3'b000)
      $display("FAIL reset_flags got %b exp 000", {lu_ready, pipe_hold, id_stall}); else n_pass++;
    tick();
  endtask

  task automatic test_wb_write();
    idle_inputs();
    wb_valid = 1; wb_waddr = 5'd3; wb_wdata = 32'h11;
    settle();
    n_total++; if (rf_we !== 4'hf || rf_waddr !== 5'd3 || rf_wdata !== 32'h11)
      $display("FAIL wb_write got %h/%0d/%h exp f/3/11", rf_we, rf_waddr, rf_wdata); else n_pass++;
    n_total++; if (lu_ready !== 1'b0) $display("FAIL wb_lu_ready got %b exp 0", lu_ready); else n_pass++;
    tick();
  endtask

  task automatic test_lu_write();
    idle_inputs();
    iss_valid = 1; iss_rd = 5'd7;
    settle(); tick();
    idle_inputs();
    lu_valid = 1; lu_waddr = 5'd7; lu_wdata = 32'hAB; id_raddr1 = 5'd7;
    settle();
    n_total++; if (lu_ready !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hAB || rf_we !== 4'hf)
      $display("FAIL lu_write got rdy=%b %0d/%h we=%h exp 1 7/ab f", lu_ready, rf_waddr, rf_wdata, rf_we);
    else n_pass++;
    n_total++; if (id_stall !== 1'b1) $display("FAIL lu_stall_before_clear got %b exp 1", id_stall); else n_pass++;
    tick();
    lu_valid = 0;
    settle();
    n_total++; if (id_stall !== 1'b0) $display("FAIL lu_stall_after_clear got %b exp 0", id_stall); else n_pass++;
    tick();
  endtask

  task automatic test_starve();
    idle_inputs();
    lu_valid = 1; lu_waddr = 5'd12; lu_wdata = 32'hC0DE;
    for (int c = 1; c <= LIMIT + 3; c++) begin
      wb_valid = 1;
      if (c <= LIMIT + 1) begin wb_waddr = 5'(c); wb_wdata = 32'h100 + 32'(c); end
      if (c == LIMIT + 3) lu_valid = 0;
      settle();
      if (c <= LIMIT + 1) begin
        n_total++; if (lu_ready !== 1'b0 || pipe_hold !== 1'b0 || rf_waddr !== 5'(c))
          $display("FAIL starve_wb_c%0d got rdy=%b hold=%b addr=%0d exp 0 0 %0d", c, lu_ready, pipe_hold, rf_waddr, c);
        else n_pass++;
      end else if (c == LIMIT + 2) begin
        n_total++; if (lu_ready !== 1'b1 || pipe_hold !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 32'hC0DE)
          $display("FAIL starve_force got rdy=%b hold=%b addr=%0d data=%h exp 1 1 12 c0de", lu_ready, pipe_hold, rf_waddr, rf_wdata);
        else n_pass++;
      end else begin
        n_total++; if (pipe_hold !== 1'b0 || lu_ready !== 1'b0 || rf_waddr !== wb_waddr)
          $display("FAIL starve_after got hold=%b rdy=%b addr=%0d exp 0 0 %0d", pipe_hold, lu_ready, rf_waddr, wb_waddr);
        else n_pass++;
      end
      tick();
    end
    idle_inputs();
    settle(); tick();
  endtask

  task automatic test_scoreboard();
    idle_inputs();
    iss_valid = 1; iss_rd = 5'd9; id_raddr2 = 5'd9;
    settle();
    n_total++; if (id_stall !== 1'b0) $display("FAIL sb_issue_cycle got %b exp 0", id_stall); else n_pass++;
    tick();
    iss_valid = 0;
    for (int k = 0; k < 3; k++) begin
      wb_valid = 1; wb_waddr = 5'(20 + k); wb_wdata = 32'(k);
      settle();
      n_total++; if (id_stall !== 1'b1) $display("FAIL sb_pending_c%0d got %b exp 1", k, id_stall); else n_pass++;
      tick();
    end
    wb_valid = 0; lu_valid = 1; lu_waddr = 5'd9; lu_wdata = 32'h99;
    settle();
    n_total++; if (id_stall !== 1'b1 || lu_ready !== 1'b1)
      $display("FAIL sb_grant_cycle got stall=%b rdy=%b exp 1 1", id_stall, lu_ready); else n_pass++;
    tick();
    lu_valid = 0;
    settle();
    n_total++; if (id_stall !== 1'b0) $display("FAIL sb_after_grant got %b exp 0", id_stall); else n_pass++;
    tick();
    idle_inputs();
    iss_valid = 1; iss_rd = 5'd0;
    settle(); tick();
    iss_valid = 0; id_raddr1 = 5'd0; id_raddr2 = 5'd0; id_waddr = 5'd0;
    settle();
    n_total++; if (id_stall !== 1'b0) $display("FAIL sb_r0 got %b exp 0", id_stall); else n_pass++;
    tick();
  endtask

  task automatic test_set_wins();
    idle_inputs();
    iss_valid = 1; iss_rd = 5'd4;
    lu_valid = 1; lu_waddr = 5'd4; lu_wdata = 32'h44;
    settle();
    n_total++; if (lu_ready !== 1'b1) $display("FAIL setwin_grant got %b exp 1", lu_ready); else n_pass++;
    tick();
    idle_inputs();
    id_raddr1 = 5'd4;
    settle();
    n_total++; if (id_stall !== 1'b1) $display("FAIL setwin_pending got %b exp 1", id_stall); else n_pass++;
    tick();
    id_raddr1 = 5'd0; id_waddr = 5'd4;
    settle();
    n_total++; if (id_stall !== 1'b1) $display("FAIL waw_stall got %b exp 1", id_stall); else n_pass++;
    tick();
    idle_inputs();
    lu_valid = 1; lu_waddr = 5'd4; lu_wdata = 32'h45;
    settle(); tick();
    idle_inputs();
    settle(); tick();
  endtask

  task automatic test_async_reset();
    idle_inputs();
    iss_valid = 1; iss_rd = 5'd5;
    settle(); tick();
    idle_inputs();
    wb_valid = 1; wb_waddr = 5'd1; wb_wdata = 32'h1;
    lu_valid = 1; lu_waddr = 5'd5; lu_wdata = 32'h55;
    settle(); tick();
    id_raddr1 = 5'd5;
    settle();
    n_total++; if (id_stall !== 1'b1) $display("FAIL areset_pre_stall got %b exp 1", id_stall); else n_pass++;
    #2;
    idle_inputs();
    id_raddr1 = 5'd5;
    reset = 1;
    #1;
    model_reset();
    n_total++; if (rf_we !== 4'h0 || pipe_hold !== 1'b0 || lu_ready !== 1'b0)
      $display("FAIL areset_outputs got we=%h hold=%b rdy=%b exp 0 0 0", rf_we, pipe_hold, lu_ready);
    else n_pass++;
    n_total++; if (id_stall !== 1'b0) $display("FAIL areset_pending got %b exp 0", id_stall); else n_pass++;
    #1 reset = 0;
    @(posedge clk); model_commit(); #1;
  endtask

  task automatic test_random();
    bit lu_taken = 1'b1;
    bit hold_next;
    idle_inputs();
    for (int cyc = 0; cyc < 400; cyc++) begin
      hold_next = (m_wait == LIMIT + 1);
      if (!hold_next) begin
        wb_valid = ($urandom_range(0, 99) < 60);
        wb_waddr = 5'($urandom); wb_wdata = $urandom;
      end
      if (!lu_valid || lu_taken) begin
        lu_valid = ($urandom_range(0, 99) < 45);
        lu_waddr = 5'($urandom_range(0, 7)); lu_wdata = $urandom;
      end
      id_raddr1 = 5'($urandom_range(0, 7));
      id_raddr2 = 5'($urandom_range(0, 7));
      id_waddr  = 5'($urandom_range(0, 7));
      iss_rd    = 5'($urandom_range(0, 7));
      model_eval();
      iss_valid = !hold_next && !e_stall && ($urandom_range(0, 2) == 0);
      settle();
      n_total++; if (rf_we !== e_we || rf_waddr !== e_addr || rf_wdata !== e_data)
        $display("FAIL rand_port c%0d got %h/%0d/%h exp %h/%0d/%h", cyc, rf_we, rf_waddr, rf_wdata, e_we, e_addr, e_data);
      else n_pass++;
      n_total++; if (lu_ready !== e_lu || pipe_hold !== e_hold)
        $display("FAIL rand_ctrl c%0d got rdy=%b hold=%b exp %b %b", cyc, lu_ready, pipe_hold, e_lu, e_hold);
      else n_pass++;
      n_total++; if (id_stall !== e_stall)
        $display("FAIL rand_stall c%0d got %b exp %b", cyc, id_stall, e_stall);
      else n_pass++;
      lu_taken = e_lu;
      tick();
    end
    idle_inputs();
    settle(); tick();
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    model_reset();
    #22 reset = 0;
    @(posedge clk); #1;
    test_reset();
    test_wb_write();
    test_lu_write();
    test_starve();
    test_scoreboard();
    test_set_wins();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
